// File: rtl/gpu_shader_pkg.sv
// Shared definitions for the shader accelerator stages: sizes that must agree
// with the top-level controller and the matadd_engine state encoding.
package GPU_Shader_pkg;

  localparam int MATADD_LANES  = 4;   // elements per burst, one scratchpad word per lane
  localparam int MATADD_ADDR_W = 8;   // scratchpad word-address width
  localparam int MATADD_DATA_W = 32;  // element width
  localparam int MATADD_RD_LAT = 1;   // scratchpad read data arrives one cycle after request
  localparam int MATADD_OFF_W  = 9;   // offset reaches 256 when length=255, so one spare bit

  // Walk of one burst: read A, read B (capture A), capture B and add, write C.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CAP_B = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } matadd_state_t;

endpackage

// File: rtl/matadd_engine.sv
// Element-wise C = A + B over the scratchpad, LANES elements per burst.
// Handshake: start is a single-cycle request sampled only in IDLE (no ready);
// busy covers the whole operation and done pulses once for retirement.
// Memory reads return data exactly MATADD_RD_LAT cycles after mem_rd_en.
module matadd_engine
  import GPU_Shader_pkg::*;
#(
  parameter int LANES  = MATADD_LANES,
  parameter int ADDR_W = MATADD_ADDR_W,
  parameter int DATA_W = MATADD_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_a,
  input  logic [ADDR_W-1:0]       base_b,
  input  logic [ADDR_W-1:0]       base_c,
  input  logic [7:0]              length,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_rd_addr,
  input  logic [LANES*DATA_W-1:0] mem_rd_data,
  output logic                    mem_wr_en,
  output logic [ADDR_W-1:0]       mem_wr_addr,
  output logic [LANES*DATA_W-1:0] mem_wr_data,
  output logic [LANES-1:0]        mem_wr_mask
);

  matadd_state_t state_q, state_d;

  logic [MATADD_OFF_W-1:0] offset_q;
  logic [MATADD_OFF_W-1:0] offset_next;
  logic [ADDR_W-1:0]       offset_addr;
  logic [ADDR_W-1:0]       base_a_q, base_b_q, base_c_q;
  logic [7:0]              length_q;
  logic [LANES*DATA_W-1:0] a_q, sum_q, lane_sum;
  logic [LANES-1:0]        lane_mask;
  logic                    last_burst;

  // Offset wraps modulo the address space when added to a base.
  assign offset_addr = ADDR_W'(offset_q);
  assign offset_next = offset_q + MATADD_OFF_W'(LANES);
  assign last_burst  = (offset_next >= {1'b0, length_q});

  // Per-lane modular adders and tail masks (lanes past length are never written).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_sum[i*DATA_W +: DATA_W] = a_q[i*DATA_W +: DATA_W] + mem_rd_data[i*DATA_W +: DATA_W];
    assign lane_mask[i] = ({1'b0, offset_q} + 10'(i)) < {2'b00, length_q};
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and Moore outputs; all outputs idle at zero outside their state.
  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_wr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (length == 8'd0) ? ST_DONE : ST_RD_A;
      end
      ST_RD_A: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_a_q + offset_addr;
        state_d     = ST_RD_B;
      end
      ST_RD_B: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_b_q + offset_addr;
        state_d     = ST_CAP_B;
      end
      ST_CAP_B: begin
        busy    = 1'b1;
        state_d = ST_WR;
      end
      ST_WR: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_addr = base_c_q + offset_addr;
        mem_wr_data = sum_q;
        mem_wr_mask = lane_mask;
        state_d     = last_burst ? ST_DONE : ST_RD_A;
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch on accepted start, A/sum capture, and burst offset advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      length_q <= '0;
      a_q      <= '0;
      sum_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_a_q <= base_a;
            base_b_q <= base_b;
            base_c_q <= base_c;
            length_q <= length;
            offset_q <= '0;
          end
        end
        ST_RD_B:  a_q      <= mem_rd_data;   // A vector returned from the RD_A request
        ST_CAP_B: sum_q    <= lane_sum;      // B vector is on mem_rd_data this cycle
        ST_WR:    offset_q <= offset_next;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matadd_engine.md
Name: matadd_engine

Overview:
Accelerator stage dispatched by the GPU top-level controller when it decodes OP_MATADD; it consumes the decoded operands (baseA, baseB, baseC from lane-0 registers, length from imm8). It streams LANES-wide bursts from the scratchpad, adds element-wise and writes results back with a per-lane mask. It returns a one-cycle done pulse so the controller can retire the instruction.

Parameters:
LANES, 4, elements processed per burst (one scratchpad word per lane)
ADDR_W, 8, scratchpad word-address width (depth 2**ADDR_W = 256)
DATA_W, 32, element width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  dispatch pulse; sampled only in IDLE
base_a  in  ADDR_W  word address of operand A[0]
base_b  in  ADDR_W  word address of operand B[0]
base_c  in  ADDR_W  word address of result C[0]
length  in  8  element count (0..255)
busy  out  1  high from the cycle after accepted start through DONE
done  out  1  one-cycle completion pulse
mem_rd_en  out  1  vector read request
mem_rd_addr  out  ADDR_W  base word address of read vector (lane i reads addr+i)
mem_rd_data  in  LANES*DATA_W  read vector; lane i in bits [i*DATA_W +: DATA_W]; valid exactly one cycle after request
mem_wr_en  out  1  vector write strobe
mem_wr_addr  out  ADDR_W  base word address of write vector
mem_wr_data  out  LANES*DATA_W  write vector, same lane packing
mem_wr_mask  out  LANES  per-lane write enable

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, mem_rd_en, mem_wr_en, mem_wr_mask = 0; addresses/data = 0; offset and operand registers cleared. Reset mid-operation aborts immediately; no further write issued.
- Latched on accepted start: base_a/b/c, length; offset <= 0.
- FSM states: IDLE, RD_A, RD_B, CAP_B, WR, DONE.
- IDLE: start=1 -> RD_A if length!=0, else DONE. start while not IDLE is ignored.
- RD_A: mem_rd_en=1, addr=base_a+offset -> RD_B.
- RD_B: capture mem_rd_data as A vector at end of cycle; mem_rd_en=1, addr=base_b+offset -> CAP_B.
- CAP_B: capture mem_rd_data as B vector; sum register <= A+B per lane -> WR.
- WR: mem_wr_en=1, addr=base_c+offset, data=sum, mask lane i = (offset+i < length); offset += LANES; if new offset >= length -> DONE else RD_A.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE (busy drops).
- Latency: with start sampled at edge 0, bursts=ceil(length/LANES); done is high in the cycle after edge 4*bursts+1 (length=0: after edge 1). Back-to-back start accepted in the IDLE cycle following DONE.
- Arithmetic: per-lane sum modulo 2**DATA_W, carry discarded. Address sums modulo 2**ADDR_W (wrap to 0); lanes addr+i also wrap.
- Offset held in 9 bits so length=255 terminates without overflow.
- Tail lanes are read but never written (mask=0). Read and write ports never active in the same cycle.
- Aliasing: each burst reads A and B before writing C, so base_c==base_a (in-place) is correct; overlapping partial bursts are not supported.

Decomposition:
- Shared package GPU_Shader_pkg: matadd_state_t enum (six states), MATADD_RD_LAT=1 constant, lane/width constants aligned with the top-level LANES.
- No sub-module required; per-lane adder and mask generation are generate loops inside the block.

Test Plan:
- length=6, LANES=4, A[16+i]=i, B[64+i]=5i, C[128..]=0xDEAD -> C[128+i]=6i for i=0..5, C[134],C[135] stay 0xDEAD, mask 1111 then 0011, done after edge 9.
- length=0, start -> no mem_rd_en/mem_wr_en, done pulses after edge 1, busy high exactly one cycle.
- A=0xFFFF_FFFF, B=1 on lane 0; A=0x8000_0000, B=0x8000_0000 on lane 1 -> C=0 on both (carry dropped).
- base_a=254, base_b=0, base_c=252, length=4 -> reads of A wrap to addresses 254,255,0,1; writes to 252..255; all four sums correct.
- In-place: base_c=base_a=32, length=8 -> C=A+B correct for all 8; assert rst_n=0 during second burst's RD_B -> busy/done/mem_* go 0 asynchronously, second-burst C words unchanged.
- start pulsed again while busy -> ignored (single done); start in IDLE cycle right after DONE -> second op accepted and completes correctly.
